reg_write_arbiter: RTL

- Write-side front end for the CPU register file; the only block that drives the register file's write_en / write_addr / write_data.
- Merges two writeback sources:
  - Port A: single-cycle pipeline (ALU / load path). No backpressure, highest priority.
  - Port B: long-latency unit (mult/div). Ready/valid handshake, buffered in a small FIFO.
- Exports a per-register pending scoreboard so the decode stage can stall reads of registers whose value is still in flight.

---
 rtl/reg_write_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: write-side front end of the CPU register file.
// Merges a no-backpressure single-cycle port A with a FIFO-buffered
// ready/valid port B. Exports a per-register pending scoreboard for decode.
// Port A is always program-newer than anything queued from port B. An A write
// therefore kills older queued B entries to the same register.
module reg_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // FIFO storage: one valid bit and one kill bit per slot
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0]  ent_vld_q;
  logic [DEPTH-1:0]  ent_kill_q;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // live_q rises on the first edge after reset release and gates b_ready
  logic              live_q;

  logic              a_issue_s;
  logic              b_xfer_s;
  logic              b_push_s;
  logic              pop_s;
  logic              head_kill_s;
  logic              push_kill_s;

  // Decode this cycle's requests: accept, push and pop
  always_comb begin
    a_issue_s   = a_valid && (a_addr != {ADDR_W{1'b0}});
    b_ready     = live_q && (count_q < DEPTH_C) && !flush;
    b_xfer_s    = b_valid && b_ready;
    // A transfer to register 0 completes the handshake but is dropped
    b_push_s    = b_xfer_s && (b_addr != {ADDR_W{1'b0}});
    // A owns the write port whenever it issues. A flush discards the head
    // instead of issuing it.
    pop_s       = !a_issue_s && (count_q != {CNT_W{1'b0}}) && !flush;
    head_kill_s = ent_kill_q[rd_ptr_q];
    // Same-cycle B to the register A is writing is older than A: enqueue it dead
    push_kill_s = a_issue_s && (b_addr == a_addr);
  end

  // Next-state pointers and occupancy count
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (b_push_s) begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({b_push_s, pop_s})
        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state of the registered write port: A first, then the FIFO head
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_issue_s) begin
      we_d    = 1'b1;
      waddr_d = a_addr;
      wdata_d = a_data;
    end else if (pop_s) begin
      // A killed head is retired silently
      we_d    = !head_kill_s;
      waddr_d = ent_addr_q[rd_ptr_q];
      wdata_d = ent_data_q[rd_ptr_q];
    end else begin
      we_d    = 1'b0;
    end
  end

  // Control state: pointers, count, output register and the live flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      we_q     <= 1'b0;
      waddr_q  <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      live_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      live_q   <= 1'b1;
    end
  end

  // FIFO slots: kill matching entries on A issue, retire on pop, fill on push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld_q  <= {DEPTH{1'b0}};
      ent_kill_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= {ADDR_W{1'b0}};
        ent_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      ent_vld_q  <= {DEPTH{1'b0}};
      ent_kill_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_issue_s && ent_vld_q[i] && (ent_addr_q[i] == a_addr)) begin
          ent_kill_q[i] <= 1'b1;
        end
      end
      if (pop_s) begin
        ent_vld_q[rd_ptr_q] <= 1'b0;
      end
      // The write slot is never valid when a push is allowed, so no clash with the kill loop
      if (b_push_s) begin
        ent_vld_q[wr_ptr_q]  <= 1'b1;
        ent_kill_q[wr_ptr_q] <= push_kill_s;
        ent_addr_q[wr_ptr_q] <= b_addr;
        ent_data_q[wr_ptr_q] <= b_data;
      end
    end
  end

  // Scoreboard from state only: live queued entries plus the write in the output register
  always_comb begin
    pending = 32'h0000_0000;
    for (int r = 1; r < 32; r++) begin
      pending[r] = we_q && (waddr_q == ADDR_W'(r));
      for (int i = 0; i < DEPTH; i++) begin
        pending[r] = pending[r] |
                     (ent_vld_q[i] && !ent_kill_q[i] && (ent_addr_q[i] == ADDR_W'(r)));
      end
    end
  end

  assign write_en   = we_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign fifo_count = count_q;

endmodule
